sd_dfc_rcrx: RTL and testbench
==============================

# sd_dfc_rcrx

Delayed-flow-control receiver. It sits at the far end of a DFC link from `sd_dfc_rctx` and converts registered `p_vld`/`p_fc_n` signalling back into a srdy/drdy consumer interface. A skid FIFO absorbs the data still in flight after flow control is asserted. An optional windowed monitor flags sustained backpressure generated by this receiver.

## Interface
Parameters:
- `width`, 8: data width.
- `depth`, 8: skid FIFO entries. Must be a power of two, ≥ `skid`+1.
- `asz`, 3: log2(`depth`).
- `skid`, 4: entries reserved for in-flight words. Must be ≥ 3 when paired with `sd_dfc_rctx` default settings (`regpin`=1, `regpout`=1).
- `rc_ctr_sz`, 8: monitor counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `p_vld` in 1: link word valid, from the transmitter.
- `p_data` in `width`: link data.
- `p_fc_n` out 1: registered flow control to the transmitter; 1 = may send.
- `c_srdy` out 1: consumer data available.
- `c_drdy` in 1: consumer accepts.
- `c_data` out `width`: consumer data, the FIFO head.
- `overflow` out 1: sticky error; `p_vld` arrived while the FIFO was full.
- `window_size` in `rc_ctr_sz`: monitor window length in cycles.
- `mon_fc_thd` in `rc_ctr_sz`: backpressure cycle threshold.
- `mon_triggered` out 1: threshold exceeded in the current window.

## Operation
- **FIFO.** `wr_ptr`/`rd_ptr` are `asz`+1 bits. `count` = `wr_ptr` − `rd_ptr`, modulo 2^(`asz`+1).
  - empty: `count`==0. full: `count`==`depth`.
- **Write.** Every cycle with `p_vld`=1 and not full writes `p_data` to `mem[wr_ptr[asz-1:0]]` and increments `wr_ptr`. There is no handshake on the link side.
- **Overflow.** `p_vld`=1 while full drops the word, sets `overflow`, and leaves pointers unchanged. `overflow` clears only on `rst`.
- **Read.**
  - `c_srdy` = ~empty.
  - `c_data` = `mem[rd_ptr[asz-1:0]]`, combinational from the storage array.
  - `c_srdy`&`c_drdy` increments `rd_ptr`.
- **Simultaneous read and write.** Both occur. When full, a write in the same cycle as a read is still dropped, because the full check uses the current `count`.
- **Flow control.** `nxt_count` = `count` + write − read. `p_fc_n` <= (`depth` − `nxt_count`) > `skid`.
- **Monitor** (when compiled in):
  - `window_ctr` counts 0..`window_size`−1, then wraps to 0.
  - `fc_ctr` increments on each cycle with `p_fc_n`==0. It resets to that cycle's increment when `nxt_window_ctr`==0.
  - `mon_triggered` <= (`nxt_fc_ctr` > `mon_fc_thd`). It stays high for the rest of the window and is re-evaluated after wrap.
  - `window_size`==0: `window_ctr` and `fc_ctr` are held at 0 and `mon_triggered`=0.
  - Counter adds are `rc_ctr_sz` bits wide and saturate at all-ones; they never wrap inside a window.

## Timing
- **Reset values:**
  - `p_fc_n`=0, `c_srdy`=0, `overflow`=0, `mon_triggered`=0.
  - Pointers and counters are 0. `c_data` is don't-care while `c_srdy`=0.
- **First cycle after reset.** `p_fc_n` rises on the first clock with `rst`=0, so the transmitter sees credit one cycle after reset release.
- **Latency.** A word on `p_vld` at cycle N is visible on `c_srdy`/`c_data` at N+1.
- **Flow-control update.** `p_fc_n` reflects the occupancy after the previous cycle's transfers, i.e. one register stage.
- **Draining.** When the FIFO drains so that `depth` − `count` > `skid`, `p_fc_n` returns to 1 on the next clock.
- **Reset mid-operation.** Any cycle with `rst` high empties the FIFO, drops `p_fc_n` to 0 and clears the monitor. Words in flight on the link during reset are discarded.

## Configuration
- `SD_DFC_RCRX_MON_EN` defined: the window monitor is built as described.
- Not defined:
  - No monitor counters are built.
  - `mon_triggered` is tied to 0.
  - `window_size` and `mon_fc_thd` are unused.
  - FIFO and flow-control behaviour are identical in both cases.

## Test plan
- **Streaming.** Reset, then `p_vld`=1 for 20 cycles with incrementing data and `c_drdy`=1 → `c_data` sequence 0..19 in order; `p_fc_n` stays 1 after the first post-reset cycle; `overflow`=0.
- **Backpressure with rctx.** `c_drdy`=0 with `depth`=8, `skid`=4, rctx sending continuously → `p_fc_n` falls once 4 words are held; at most 8 words total are stored; `overflow` stays 0.
- **Drain and resume.** From the previous full state, `c_drdy`=1 → `p_fc_n` returns to 1 one clock after free slots exceed 4; data continues without loss or duplication.
- **Forced overflow.** Raw `p_vld`=1 ignoring `p_fc_n`, with `c_drdy`=0 → `overflow`=1 on the 9th word and stays set; the FIFO keeps the first 8 words.
- **Monitor** (`SD_DFC_RCRX_MON_EN`). `window_size`=16, `mon_fc_thd`=5, `c_drdy`=0 with traffic → `mon_triggered` rises on the 6th backpressure cycle of the window and clears after the wrap if backpressure stops. With `window_size`=0, `mon_triggered` stays 0.
- **Reset mid-stream.** Assert `rst` for one cycle with 3 words buffered → next cycle `c_srdy`=0 and `p_fc_n`=0; the following cycle `p_fc_n`=1; the old words are never delivered.

Source files
------------

// File: rtl/sd_dfc_rcrx.sv
// Delayed-flow-control receiver: skid FIFO behind a registered p_fc_n.
// Define SD_DFC_RCRX_MON_EN to build the windowed backpressure monitor.
module sd_dfc_rcrx #(
  parameter int width     = 8,
  parameter int depth     = 8,
  parameter int asz       = 3,
  parameter int skid      = 4,
  parameter int rc_ctr_sz = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 p_vld,
  input  logic [width-1:0]     p_data,
  output logic                 p_fc_n,
  output logic                 c_srdy,
  input  logic                 c_drdy,
  output logic [width-1:0]     c_data,
  output logic                 overflow,
  input  logic [rc_ctr_sz-1:0] window_size,
  input  logic [rc_ctr_sz-1:0] mon_fc_thd,
  output logic                 mon_triggered
);

  localparam logic [asz:0] DEPTH_C = (asz+1)'(depth);
  localparam logic [asz:0] FC_LIM  = (asz+1)'(depth - skid);
  localparam logic [asz:0] PONE    = (asz+1)'(1);

  logic [width-1:0] r_mem [depth];
  logic [asz:0]     r_wr_ptr;
  logic [asz:0]     r_rd_ptr;
  logic             r_fc_n;
  logic             r_ovf;

  logic [asz:0] w_count;
  logic [asz:0] w_nxt_count;
  logic         w_full;
  logic         w_wr;
  logic         w_rd;

  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_full  = (w_count == DEPTH_C);
  assign w_wr    = p_vld & ~w_full;
  assign w_rd    = c_srdy & c_drdy;

  assign w_nxt_count = w_count
                     + {{asz{1'b0}}, w_wr}
                     - {{asz{1'b0}}, w_rd};

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr[asz-1:0]] <= p_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fc_n   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + PONE;
      // free slots after this cycle must exceed the skid reserve
      r_fc_n <= (w_nxt_count < FC_LIM);
      r_ovf  <= r_ovf | (p_vld & w_full);
    end
  end

  assign c_srdy   = (w_count != '0);
  assign c_data   = r_mem[r_rd_ptr[asz-1:0]];
  assign p_fc_n   = r_fc_n;
  assign overflow = r_ovf;

`ifdef SD_DFC_RCRX_MON_EN
  localparam logic [rc_ctr_sz-1:0] ONE  = rc_ctr_sz'(1);
  localparam logic [rc_ctr_sz-1:0] ONES = '1;

  logic [rc_ctr_sz-1:0] r_win;
  logic [rc_ctr_sz-1:0] r_fc_ctr;
  logic                 r_trig;
  logic [rc_ctr_sz-1:0] w_nxt_win;
  logic [rc_ctr_sz-1:0] w_nxt_fc;
  logic                 w_bp;

  assign w_bp = ~r_fc_n;

  always_comb begin
    w_nxt_win = '0;
    w_nxt_fc  = '0;
    if (window_size != '0) begin
      if (r_win >= window_size - ONE) w_nxt_win = '0;
      else                            w_nxt_win = r_win + ONE;
      // a new window starts with this cycle's contribution
      if (w_nxt_win == '0)
        w_nxt_fc = {{(rc_ctr_sz-1){1'b0}}, w_bp};
      else if (w_bp && (r_fc_ctr != ONES))
        w_nxt_fc = r_fc_ctr + ONE;
      else
        w_nxt_fc = r_fc_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_win    <= '0;
      r_fc_ctr <= '0;
      r_trig   <= 1'b0;
    end else begin
      r_win    <= w_nxt_win;
      r_fc_ctr <= w_nxt_fc;
      r_trig   <= (w_nxt_fc > mon_fc_thd);
    end
  end

  assign mon_triggered = r_trig;
`else
  logic w_unused;
  assign w_unused      = ^{window_size, mon_fc_thd};
  assign mon_triggered = 1'b0;
`endif

endmodule

// File: tb/tb_sd_dfc_rcrx.sv
// Self-checking bench for sd_dfc_rcrx against a queue-based reference.
// Monitor expectations apply only when SD_DFC_RCRX_MON_EN is defined.
module tb_sd_dfc_rcrx;

  localparam int DEPTH = 8;
  localparam int SKID  = 4;
`ifdef SD_DFC_RCRX_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       p_vld;
  logic [7:0] p_data;
  logic       p_fc_n;
  logic       c_srdy;
  logic       c_drdy;
  logic [7:0] c_data;
  logic       overflow;
  logic [7:0] window_size;
  logic [7:0] mon_fc_thd;
  logic       mon_triggered;

  sd_dfc_rcrx dut (
    .clk           (clk),
    .rst           (rst),
    .p_vld         (p_vld),
    .p_data        (p_data),
    .p_fc_n        (p_fc_n),
    .c_srdy        (c_srdy),
    .c_drdy        (c_drdy),
    .c_data        (c_data),
    .overflow      (overflow),
    .window_size   (window_size),
    .mon_fc_thd    (mon_fc_thd),
    .mon_triggered (mon_triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  logic [7:0] q[$];
  bit m_fc;
  bit m_ov;
  int m_pos;
  int m_bp;
  bit m_trig;

  task automatic tick(input logic r, input logic v,
                      input logic [7:0] d, input logic dr);
    bit old_fc;
    bit full;
    bit rd;
    rst    = r;
    p_vld  = v;
    p_data = d;
    c_drdy = dr;
    old_fc = m_fc;
    if (r) begin
      q.delete();
      m_fc = 0; m_ov = 0; m_pos = 0; m_bp = 0; m_trig = 0;
    end else begin
      full = (q.size() == DEPTH);
      rd   = (q.size() != 0) && dr;
      if (v && full) m_ov = 1;
      if (rd) void'(q.pop_front());
      if (v && !full) q.push_back(d);
      m_fc = (DEPTH - q.size()) > SKID;
      if (window_size == 0) begin
        m_pos = 0; m_bp = 0;
      end else if (m_pos >= int'(window_size) - 1) begin
        m_pos = 0; m_bp = old_fc ? 0 : 1;
      end else begin
        m_pos++;
        m_bp = m_bp + (old_fc ? 0 : 1);
        if (m_bp > 255) m_bp = 255;
      end
      m_trig = m_bp > int'(mon_fc_thd);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    checks++;
    if ({p_fc_n, c_srdy, overflow, mon_triggered} !== 4'b0000) begin
      errs++;
      $display("FAIL reset_vals got fc=%b srdy=%b ov=%b trig=%b want 0000",
               p_fc_n, c_srdy, overflow, mon_triggered);
    end
    tick(0, 0, 0, 0);
    checks++;
    if (p_fc_n !== 1'b1) begin
      errs++;
      $display("FAIL first_credit got %b want 1", p_fc_n);
    end
  endtask

  task automatic test_stream;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick(0, 1, 8'(i), 1);
      checks++;
      if (c_srdy !== 1'b1 || c_data !== 8'(i)) begin
        errs++;
        $display("FAIL stream_data[%0d] got srdy=%b data=%0d want 1/%0d",
                 i, c_srdy, c_data, i);
      end
      checks++;
      if (p_fc_n !== 1'b1 || overflow !== 1'b0) begin
        errs++;
        $display("FAIL stream_fc[%0d] got fc=%b ov=%b want 1/0",
                 i, p_fc_n, overflow);
      end
    end
  endtask

  task automatic test_backpressure;
    bit d1;
    bit d2;
    bit cur;
    bit seen_fall;
    tick(1, 0, 0, 0);
    d1 = 0; d2 = 0; seen_fall = 0;
    for (int i = 0; i < 20; i++) begin
      cur = p_fc_n;
      tick(0, d2, 8'($urandom), 0);
      d2 = d1; d1 = cur;
      if (p_fc_n === 1'b0 && q.size() >= SKID) seen_fall = 1;
      checks++;
      if (p_fc_n !== m_fc || overflow !== 1'b0) begin
        errs++;
        $display("FAIL bp_fc[%0d] got fc=%b ov=%b want %b/0",
                 i, p_fc_n, overflow, m_fc);
      end
      checks++;
      if (c_srdy !== (q.size() != 0) ||
          (q.size() != 0 && c_data !== q[0])) begin
        errs++;
        $display("FAIL bp_head[%0d] got srdy=%b data=%0h", i, c_srdy, c_data);
      end
    end
    checks++;
    if (!seen_fall) begin
      errs++;
      $display("FAIL bp_fall got fc never low want low with >=4 held");
    end
    for (int i = 0; i < 20; i++) begin
      cur = p_fc_n;
      tick(0, d2, 8'($urandom), 1);
      d2 = d1; d1 = cur;
      checks++;
      if (p_fc_n !== m_fc || overflow !== 1'b0) begin
        errs++;
        $display("FAIL drain_fc[%0d] got fc=%b ov=%b want %b/0",
                 i, p_fc_n, overflow, m_fc);
      end
      checks++;
      if (c_srdy !== (q.size() != 0) ||
          (q.size() != 0 && c_data !== q[0])) begin
        errs++;
        $display("FAIL drain_head[%0d] got srdy=%b data=%0h",
                 i, c_srdy, c_data);
      end
    end
  endtask

  task automatic test_overflow;
    logic [7:0] sent [12];
    tick(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      sent[i] = 8'($urandom);
      tick(0, 1, sent[i], 0);
      checks++;
      if (overflow !== (i >= 8)) begin
        errs++;
        $display("FAIL ovf[%0d] got %b want %b", i, overflow, (i >= 8));
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (c_srdy !== 1'b1 || c_data !== sent[k]) begin
        errs++;
        $display("FAIL ovf_keep[%0d] got srdy=%b data=%0h want 1/%0h",
                 k, c_srdy, c_data, sent[k]);
      end
      tick(0, 0, 0, 1);
    end
    checks++;
    if (c_srdy !== 1'b0 || overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_end got srdy=%b ov=%b want 0/1", c_srdy, overflow);
    end
  endtask

  task automatic test_monitor;
    window_size = 16;
    mon_fc_thd  = 5;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 70; i++) begin
      if (i < 30) tick(0, 1, 8'(i), 0);
      else        tick(0, 0, 0, 1);
      checks++;
      if (mon_triggered !== (MON && m_trig)) begin
        errs++;
        $display("FAIL mon[%0d] got %b want %b",
                 i, mon_triggered, (MON && m_trig));
      end
    end
    window_size = 0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      tick(0, 1, 8'(i), 0);
      checks++;
      if (mon_triggered !== 1'b0) begin
        errs++;
        $display("FAIL mon_ws0[%0d] got %b want 0", i, mon_triggered);
      end
    end
  endtask

  task automatic test_reset_mid;
    window_size = 0;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 1, 8'(8'hA0 + i), 0);
    checks++;
    if (c_srdy !== 1'b1 || c_data !== 8'hA0) begin
      errs++;
      $display("FAIL rmid_fill got srdy=%b data=%0h want 1/a0", c_srdy, c_data);
    end
    tick(1, 1, 8'hEE, 0);
    checks++;
    if (c_srdy !== 1'b0 || p_fc_n !== 1'b0) begin
      errs++;
      $display("FAIL rmid_rst got srdy=%b fc=%b want 0/0", c_srdy, p_fc_n);
    end
    tick(0, 0, 0, 1);
    checks++;
    if (c_srdy !== 1'b0 || p_fc_n !== 1'b1) begin
      errs++;
      $display("FAIL rmid_after got srdy=%b fc=%b want 0/1", c_srdy, p_fc_n);
    end
    tick(0, 0, 0, 1);
    checks++;
    if (c_srdy !== 1'b0) begin
      errs++;
      $display("FAIL rmid_stale got srdy=%b want 0", c_srdy);
    end
  endtask

  task automatic test_random;
    window_size = 8'($urandom_range(1, 12));
    mon_fc_thd  = 8'($urandom_range(0, 6));
    tick(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
           8'($urandom), ($urandom_range(0, 1) == 1));
      checks++;
      if (c_srdy !== (q.size() != 0) ||
          (q.size() != 0 && c_data !== q[0])) begin
        errs++;
        $display("FAIL rnd_head[%0d] got srdy=%b data=%0h want %0d entries",
                 i, c_srdy, c_data, q.size());
      end
      checks++;
      if (p_fc_n !== m_fc || overflow !== m_ov ||
          mon_triggered !== (MON && m_trig)) begin
        errs++;
        $display("FAIL rnd_ctl[%0d] got fc=%b ov=%b trig=%b want %b/%b/%b",
                 i, p_fc_n, overflow, mon_triggered,
                 m_fc, m_ov, (MON && m_trig));
      end
    end
  endtask

  initial begin
    errs = 0;
    checks = 0;
    rst = 1; p_vld = 0; p_data = 0; c_drdy = 0;
    window_size = 0;
    mon_fc_thd  = 0;
    m_fc = 0; m_ov = 0; m_pos = 0; m_bp = 0; m_trig = 0;
    @(negedge clk);
    test_reset;
    test_stream;
    test_backpressure;
    test_overflow;
    test_monitor;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
